xbus_uart_tx: RTL and testbench



---
 rtl/xbus_uart_tx_pkg.sv | 47 ++++
 rtl/xbus_uart_tx_sync_fifo.sv | 79 +++++++
 rtl/xbus_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_xbus_uart_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbus_uart_tx_pkg
// Description : Shared definitions for the xbus UART transmitter: register
//               offsets, STATUS bit positions, transmitter states and the
//               decoder chip-select slot the UART occupies.
// Revision    : 1.0 - initial release
// ============================================================================
package xbus_uart_tx_pkg;

    // Register offsets, decoded from xbus_addr[3:2]
    localparam logic [1:0] c_REG_TXDATA = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_DIV    = 2'd2;
    localparam logic [1:0] c_REG_CTRL   = 2'd3;

    // STATUS register bit positions
    localparam int c_STAT_FULL  = 0;
    localparam int c_STAT_EMPTY = 1;
    localparam int c_STAT_BUSY  = 2;
    localparam int c_STAT_OVF   = 3;
    localparam int c_STAT_COUNT = 7;

    // Decoder chip-select slot for the UART (rom, ram, uart)
    localparam int c_UART_CS_SLOT = 2;

    // Transmitter frame states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Assemble the STATUS word from its fields
    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        return {17'h0, count, 3'h0, ovf, busy, empty, full};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbus_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. A push and a pop in
//               the same cycle both take effect even when full; a push into
//               a full FIFO without a pop is dropped and flagged on o_drop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_drop  = i_push && !w_do_push;

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : xbus_uart_tx
// Description : xbus responder UART transmitter. Bytes written to TXDATA are
//               queued in a FIFO and serialised as 8N1 on uart_tx with a bit
//               period of DIV+1 clocks. STATUS, DIV and CTRL are accessible
//               over the same zero-wait-state slave port.
// Revision    : 1.0 - initial release
// ============================================================================
module xbus_uart_tx
    import xbus_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RSTVAL = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xbus_cs,
    input  logic        xbus_we,
    input  logic [3:0]  xbus_be,
    input  logic [31:0] xbus_addr,
    input  logic [31:0] xbus_wdata,
    output logic [31:0] xbus_rdata,
    output logic        uart_tx
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic [1:0] w_reg_sel;
    logic       w_wr;
    logic       w_rd;
    logic       w_push;
    logic       w_ovf_clr;

    // FIFO interface
    logic [7:0]      w_fifo_rdata;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;
    logic [c_CW-1:0] w_count;

    // Software-visible registers
    logic        r_ovf;
    logic [15:0] r_div;
    logic        r_tx_en;

    // Transmitter state
    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_nxt;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_pop;
    logic        w_baud_done;

    // Address and data bits the register map does not use
    logic w_unused;
    assign w_unused = ^{xbus_addr[31:4], xbus_addr[1:0], xbus_be[3:2], xbus_wdata[31:16]};

    assign w_reg_sel   = xbus_addr[3:2];
    assign w_wr        = xbus_cs && xbus_we;
    assign w_rd        = xbus_cs && !xbus_we;
    assign w_push      = w_wr && (w_reg_sel == c_REG_TXDATA) && xbus_be[0];
    assign w_ovf_clr   = w_wr && (w_reg_sel == c_REG_STATUS) && xbus_be[0]
                         && xbus_wdata[c_STAT_OVF];
    // DIV is compared live so a mid-bit write takes effect immediately
    assign w_baud_done = (r_baud_cnt == r_div);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (xbus_wdata[7:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    // Software registers: sticky overflow, byte-writable divisor, enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_div   <= DIV_RSTVAL;
            r_tx_en <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_reg_sel == c_REG_DIV)) begin
                if (xbus_be[0]) r_div[7:0]  <= xbus_wdata[7:0];
                if (xbus_be[1]) r_div[15:8] <= xbus_wdata[15:8];
            end
            if (w_wr && (w_reg_sel == c_REG_CTRL) && xbus_be[0]) begin
                r_tx_en <= xbus_wdata[0];
            end
        end
    end

    // Transmitter state register; uart_tx is registered to stay glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Frame sequencing, FIFO pop and next line level
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_baud_nxt  = r_baud_cnt + 16'd1;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = 16'd0;
                if (r_tx_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_rdata;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // The line level follows the state being entered
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign uart_tx = r_tx;

    // Combinational read mux; zero unless a selected read is in progress
    always_comb begin
        xbus_rdata = 32'h0;
        if (w_rd) begin
            case (w_reg_sel)
                c_REG_STATUS: xbus_rdata = pack_status(w_full, w_empty, (r_state != ST_IDLE),
                                                       r_ovf, 8'(w_count));
                c_REG_DIV:    xbus_rdata = {16'h0, r_div};
                c_REG_CTRL:   xbus_rdata = {31'h0, r_tx_en};
                default:      xbus_rdata = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xbus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbus_uart_tx
// Description : Self-checking bench for xbus_uart_tx: register table, exact
//               line waveforms, overflow and full-FIFO corner cases, and
//               randomized bursts checked by a serial receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbus_uart_tx;

    localparam logic [31:0] c_BASE     = 32'h4000_0000;
    localparam logic [31:0] c_A_TXDATA = c_BASE + 32'h0;
    localparam logic [31:0] c_A_STATUS = c_BASE + 32'h4;
    localparam logic [31:0] c_A_DIV    = c_BASE + 32'h8;
    localparam logic [31:0] c_A_CTRL   = c_BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        xbus_cs;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;
    logic        uart_tx;

    int n_checks = 0;
    int n_pass   = 0;

    int         div_tb = 867;
    logic [7:0] rx_q[$];
    int         rst_epoch = 0;
    logic       exp_wave[$];

    typedef struct {
        logic        cs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];

    xbus_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RSTVAL (16'd867)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_cs    (xbus_cs),
        .xbus_we    (xbus_we),
        .xbus_be    (xbus_be),
        .xbus_addr  (xbus_addr),
        .xbus_wdata (xbus_wdata),
        .xbus_rdata (xbus_rdata),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge rst) rst_epoch++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic c);
        xbus_cs = c; xbus_we = 1'b1; xbus_addr = a; xbus_wdata = d; xbus_be = b;
        @(posedge clk);
        #1;
        xbus_cs = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0; xbus_wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic c, output logic [31:0] d);
        xbus_cs = c; xbus_we = 1'b0; xbus_addr = a;
        #1;
        d = xbus_rdata;
        xbus_cs = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, 1'b1, d);
        check(name, d, exp);
    endtask

    // Expected STATUS from its fields
    function automatic logic [31:0] status_of(input int cnt, input bit ovf, input bit busy);
        return (32'(cnt) << 7) | (32'(ovf) << 3) | (32'(busy) << 2)
             | ((cnt == 0) ? 32'h2 : 32'h0) | ((cnt == 8) ? 32'h1 : 32'h0);
    endfunction

    // One 8N1 frame: start, 8 data bits LSB first, stop; each div+1 clocks
    task automatic add_frame(input logic [7:0] b, input int div);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int r = 0; r <= div; r++) exp_wave.push_back(f[i]);
    endtask

    task automatic capture_check(input string name);
        int   bad;
        logic a;
        logic e;
        bad = -1; a = 1'b0; e = 1'b0;
        for (int i = 0; i < exp_wave.size(); i++) begin
            @(negedge clk);
            if (uart_tx !== exp_wave[i] && bad < 0) begin
                bad = i; a = uart_tx; e = exp_wave[i];
            end
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: sample %0d got %b expected %b", name, bad, a, e);
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (rx_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(rx_q.size()), 32'(n));
    endtask

    // Serial receiver model: mid-bit sampling, frames cut by reset discarded
    initial begin : rx_model
        logic       prev;
        logic [7:0] b;
        logic       stopb;
        int         ep;
        int         p;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0 && rst === 1'b0) begin
                ep = rst_epoch;
                p  = div_tb + 1;
                repeat ((p - 1) / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (p) @(negedge clk);
                stopb = uart_tx;
                if (ep == rst_epoch) begin
                    check("rx_stop_bit", 32'(stopb), 32'h1);
                    rx_q.push_back(b);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        logic [7:0]  bytes[9];
        logic [7:0]  mq[$];
        int          n;
        int          dv;
        bit          ovf;
        logic [3:0]  be;
        logic [7:0]  v;

        tbl[0]  = '{1'b1, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0000_0002};
        tbl[1]  = '{1'b1, 1'b0, c_A_DIV,    32'h0,         4'h0, 32'd867};
        tbl[2]  = '{1'b1, 1'b0, c_A_CTRL,   32'h0,         4'h0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, c_A_TXDATA, 32'h0,         4'h0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, c_A_DIV,    32'h0000_1234, 4'h1, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, c_A_DIV,    32'h0,         4'h0, 32'h0000_0334};
        tbl[6]  = '{1'b1, 1'b1, c_A_DIV,    32'h0000_AB00, 4'h2, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, c_A_DIV,    32'h0,         4'h0, 32'h0000_AB34};
        tbl[8]  = '{1'b1, 1'b1, c_A_TXDATA, 32'h0000_0055, 4'hE, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0000_0002};
        tbl[10] = '{1'b0, 1'b1, c_A_DIV,    32'h0,         4'hF, 32'h0};
        tbl[11] = '{1'b1, 1'b0, c_A_DIV,    32'h0,         4'h0, 32'h0000_AB34};
        tbl[12] = '{1'b0, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, c_A_CTRL,   32'hFFFF_FFFF, 4'hE, 32'h0};
        tbl[14] = '{1'b1, 1'b0, c_A_CTRL,   32'h0,         4'h0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, c_A_DIV,    32'hFFFF_0005, 4'hF, 32'h0};
        tbl[16] = '{1'b1, 1'b0, c_A_DIV,    32'h0,         4'h0, 32'h0000_0005};
        tbl[17] = '{1'b1, 1'b1, c_A_TXDATA, 32'h0000_0011, 4'h1, 32'h0};
        tbl[18] = '{1'b1, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0000_0080};
        tbl[19] = '{1'b0, 1'b1, c_A_TXDATA, 32'h0000_0022, 4'hF, 32'h0};
        tbl[20] = '{1'b1, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0000_0080};
        tbl[21] = '{1'b1, 1'b1, c_A_STATUS, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[22] = '{1'b1, 1'b0, c_A_STATUS, 32'h0,         4'h0, 32'h0000_0080};
        tbl[23] = '{1'b1, 1'b0, c_BASE + 32'hB, 32'h0,     4'h0, 32'h0000_0005};

        rst = 1'b1; xbus_cs = 1'b0; xbus_we = 1'b0; xbus_be = 4'h0;
        xbus_addr = 32'h0; xbus_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(uart_tx), 32'h1);
        rst = 1'b0;

        // Register table
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].we) begin
                bus_write(tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].cs);
            end else begin
                bus_read(tbl[i].addr, tbl[i].cs, d);
                check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
            end
        end

        // Reset asserted in the middle of a frame (DIV=5, FIFO holds 0x11)
        div_tb = 5;
        bus_write(c_A_TXDATA, 32'h22, 4'h1, 1'b1);
        bus_write(c_A_TXDATA, 32'h33, 4'h1, 1'b1);
        bus_write(c_A_CTRL, 32'h1, 4'h1, 1'b1);
        repeat (15) @(negedge clk);
        check("pre_rst_tx", 32'(uart_tx), 32'h0);
        #2 rst = 1'b1;
        #1 check("rst_async_tx", 32'(uart_tx), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_check("rst_status", c_A_STATUS, 32'h0000_0002);
        read_check("rst_div", c_A_DIV, 32'd867);
        read_check("rst_ctrl", c_A_CTRL, 32'h0);
        repeat (80) @(negedge clk);
        check("rst_idle_tx", 32'(uart_tx), 32'h1);
        check("rst_no_rx", 32'(rx_q.size()), 32'h0);
        rx_q.delete();

        // Single byte, exact waveform and one-cycle latency
        bus_write(c_A_DIV, 32'h3, 4'hF, 1'b1);
        div_tb = 3;
        bus_write(c_A_CTRL, 32'h1, 4'h1, 1'b1);
        exp_wave.delete();
        exp_wave.push_back(1'b1);
        add_frame(8'hA5, 3);
        exp_wave.push_back(1'b1);
        exp_wave.push_back(1'b1);
        fork
            bus_write(c_A_TXDATA, 32'hA5, 4'h1, 1'b1);
            begin
                @(posedge clk);
                capture_check("single_wave");
            end
        join
        repeat (5) @(negedge clk);
        check("single_rx_cnt", 32'(rx_q.size()), 32'h1);
        if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'hA5);
        rx_q.delete();

        // Back-to-back frames with DIV=1
        bus_write(c_A_DIV, 32'h1, 4'hF, 1'b1);
        div_tb = 1;
        exp_wave.delete();
        exp_wave.push_back(1'b1);
        add_frame(8'h00, 1);
        exp_wave.push_back(1'b1);
        add_frame(8'hFF, 1);
        exp_wave.push_back(1'b1);
        exp_wave.push_back(1'b1);
        fork
            begin
                bus_write(c_A_TXDATA, 32'h00, 4'h1, 1'b1);
                bus_write(c_A_TXDATA, 32'hFF, 4'h1, 1'b1);
                read_check("b2b_status", c_A_STATUS, status_of(1, 1'b0, 1'b1));
            end
            begin
                @(posedge clk);
                capture_check("b2b_wave");
            end
        join
        repeat (5) @(negedge clk);
        check("b2b_rx_cnt", 32'(rx_q.size()), 32'h2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", 32'(rx_q[0]), 32'h00);
            check("b2b_rx1", 32'(rx_q[1]), 32'hFF);
        end
        rx_q.delete();

        // Overflow: nine pushes into an eight-entry FIFO with tx disabled
        bus_write(c_A_CTRL, 32'h0, 4'h1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            bytes[i] = 8'($urandom);
            bus_write(c_A_TXDATA, 32'(bytes[i]), 4'h1, 1'b1);
        end
        read_check("ovf_status", c_A_STATUS, status_of(8, 1'b1, 1'b0));
        bus_write(c_A_STATUS, 32'h8, 4'h2, 1'b1);
        read_check("ovf_keep_be", c_A_STATUS, status_of(8, 1'b1, 1'b0));
        bus_write(c_A_STATUS, 32'h8, 4'h1, 1'b1);
        read_check("ovf_clear", c_A_STATUS, status_of(8, 1'b0, 1'b0));
        bus_write(c_A_CTRL, 32'h1, 4'h1, 1'b1);
        wait_rx(8, 8 * 25 + 60, "ovf_rx_wait");
        repeat (40) @(negedge clk);
        check("ovf_rx_cnt", 32'(rx_q.size()), 32'h8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            check($sformatf("ovf_rx[%0d]", i), 32'(rx_q[i]), 32'(bytes[i]));
        read_check("ovf_drained", c_A_STATUS, status_of(0, 1'b0, 1'b0));
        rx_q.delete();

        // Push and pop in the same cycle on a full FIFO
        bus_write(c_A_CTRL, 32'h0, 4'h1, 1'b1);
        for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) bus_write(c_A_TXDATA, 32'(bytes[i]), 4'h1, 1'b1);
        read_check("pf_full", c_A_STATUS, status_of(8, 1'b0, 1'b0));
        bus_write(c_A_CTRL, 32'h1, 4'h1, 1'b1);
        bus_write(c_A_TXDATA, 32'(bytes[8]), 4'h1, 1'b1);
        read_check("pf_pushpop", c_A_STATUS, status_of(8, 1'b0, 1'b1));
        wait_rx(9, 9 * 25 + 60, "pf_rx_wait");
        repeat (40) @(negedge clk);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check($sformatf("pf_rx[%0d]", i), 32'(rx_q[i]), 32'(bytes[i]));
        read_check("pf_drained", c_A_STATUS, status_of(0, 1'b0, 1'b0));
        rx_q.delete();

        // Randomized bursts against a queue model of the FIFO
        for (int it = 0; it < 6; it++) begin
            bus_write(c_A_CTRL, 32'h0, 4'h1, 1'b1);
            dv = $urandom_range(0, 6);
            bus_write(c_A_DIV, 32'(dv), 4'h3, 1'b1);
            div_tb = dv;
            n   = $urandom_range(1, 11);
            ovf = 1'b0;
            mq.delete();
            for (int k = 0; k < n; k++) begin
                v  = 8'($urandom);
                be = 4'($urandom_range(0, 15));
                bus_write(c_A_TXDATA, {24'($urandom), v}, be, 1'b1);
                if (be[0]) begin
                    if (mq.size() < 8) mq.push_back(v);
                    else ovf = 1'b1;
                end
            end
            read_check($sformatf("rnd%0d_status", it), c_A_STATUS, status_of(mq.size(), ovf, 1'b0));
            bus_write(c_A_STATUS, 32'h8, 4'h1, 1'b1);
            bus_write(c_A_CTRL, 32'h1, 4'h1, 1'b1);
            wait_rx(mq.size(), mq.size() * (10 * (dv + 1) + 2) + 60, $sformatf("rnd%0d_rx_wait", it));
            repeat (10 * (dv + 1) + 10) @(negedge clk);
            check($sformatf("rnd%0d_rx_cnt", it), 32'(rx_q.size()), 32'(mq.size()));
            for (int k = 0; k < mq.size() && k < rx_q.size(); k++)
                check($sformatf("rnd%0d_rx[%0d]", it, k), 32'(rx_q[k]), 32'(mq[k]));
            read_check($sformatf("rnd%0d_idle", it), c_A_STATUS, status_of(0, 1'b0, 1'b0));
            rx_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
